eq_serial: RTL
==============

# eq_serial

Bit-serial word equality comparator for the tutorial datapath. It accepts two operands one bit per cycle, LSB first, under a start/valid handshake. It reports whether all W bit pairs matched and, on mismatch, the index of the first differing bit. Each bit decision is made by a one-bit equality cell. The block sits between a serializer (UART or shift-register front end) and the lab's status LEDs/registers.

## Interface
- `W`, default 8: operand width in bits; legal range 2..32.
- `IW`, default `$clog2(W)`: width of the bit index (localparam, not overridable).

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: begin a new comparison; sampled only in IDLE or DONE.
- `bit_valid` input 1: `a_bit`/`b_bit` carry a valid pair this cycle.
- `a_bit` input 1: operand A serial bit.
- `b_bit` input 1: operand B serial bit.
- `busy` output 1: comparison in progress (state SHIFT).
- `done` output 1: one-cycle pulse when the result becomes valid.
- `eq` output 1: 1 if all W pairs matched; held until the next accepted start.
- `mismatch_idx` output IW: index of the first mismatching bit; meaningful only when `eq`=0 after done; held.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: consuming bits.
  - DONE: result presented, one cycle.
- IDLE: `start`=1 goes to SHIFT. On the same edge, set bit counter=0, internal match accumulator=1, first-mismatch flag=0, `eq`=0, `mismatch_idx`=0.
- SHIFT: each cycle with `bit_valid`=1:
  - acc <= acc & (a_bit ~^ b_bit).
  - If a_bit≠b_bit and the first-mismatch flag=0: `mismatch_idx` <= counter and the flag is set.
  - counter increments.
- SHIFT with `bit_valid`=0: no change (stall).
- SHIFT: when a valid pair is consumed with counter=W-1, go to DONE. On that edge, `eq` <= final acc, including the last bit.
- DONE: `done`=1 for exactly this cycle, then return to IDLE. If `start`=1 in DONE, go directly to SHIFT and reinitialise as from IDLE. `done` is still 1 in that cycle.
- `start` in SHIFT is ignored. `bit_valid` in IDLE/DONE is ignored.
- No early exit on mismatch: all W bits are always consumed, so the upstream framing stays aligned.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `eq`=0, `mismatch_idx`=0, counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency with `bit_valid` held high: start at edge n; bits sampled at edges n+1..n+W; `done`=1 during the cycle after edge n+W.
- `busy` is 1 from the cycle after start acceptance through the cycle the last bit is consumed.
- Reset asserted mid-SHIFT: next edge returns to IDLE with all reset values. A partial result is never reported.
- Back-to-back operation: start in DONE gives one comparison every W+1 cycles.

## Structure
- The `eq_serial_pkg`/shared header holds the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default W.
- Sub-module `eq_bit_cell`: the combinational one-bit equality (XNOR as sum of products), instantiated once on `a_bit`/`b_bit`.
- Top level contains the FSM, counter, accumulator, and index capture.

## Test plan
- W=8, A=B=8'hA5 streamed with continuous valid → `done` 9 cycles after start, `eq`=1.
- A=8'hA5, B=8'hA4 → `eq`=0, `mismatch_idx`=0. A=8'h25, B=8'hA5 → `eq`=0, `mismatch_idx`=7 (last bit caught).
- A=8'h0F, B=8'hF0 with `bit_valid` toggling every other cycle → `eq`=0, `mismatch_idx`=0, `done` 17 cycles after start; `busy` stays high through the stalls.
- Start pulsed during SHIFT, and `bit_valid` pulsed in IDLE → no effect; result matches an undisturbed run.
- Reset after 4 bits → next cycle IDLE, `eq`=0, `busy`=0, no `done`. A fresh A=B=8'h3C run → `eq`=1.
- Two back-to-back comparisons (start held high in DONE): 8'hFF vs 8'hFF, then 8'h00 vs 8'h01 → `done` pulses 9 cycles apart; `eq` 1 then 0, `mismatch_idx`=0.

Source files
------------

// File: rtl/eq_serial_pkg.sv
// Shared definitions for the bit-serial equality comparator: FSM state
// encoding and the default operand width.
package eq_serial_pkg;

    localparam int EQ_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/eq_serial_if.sv
// Serial operand / result bundle between the front-end serializer (master)
// and the comparator (slave).
interface eq_serial_if
    import eq_serial_pkg::*;
#(
    parameter int W = EQ_W_DEFAULT
) ();
    localparam int IW = $clog2(W);

    logic          start;
    logic          bit_valid;
    logic          a_bit;
    logic          b_bit;
    logic          busy;
    logic          done;
    logic          eq;
    logic [IW-1:0] mismatch_idx;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, eq, mismatch_idx
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, eq, mismatch_idx
    );

endinterface

// File: rtl/eq_bit_cell.sv
// One-bit equality cell: XNOR written as a sum of products.
module eq_bit_cell (
    input  logic a,
    input  logic b,
    output logic eq
);

    assign eq = (a & b) | (~a & ~b);

endmodule

// File: rtl/eq_serial.sv
// Bit-serial word comparator: consumes W bit pairs LSB first and reports
// whole-word equality plus the index of the first differing bit.
module eq_serial
    import eq_serial_pkg::*;
#(
    parameter int W = EQ_W_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    eq_serial_if.slave bus
);

    localparam int IW = $clog2(W);

    state_t        state_reg;
    state_t        state_next;
    logic          busy_reg;
    logic          busy_next;
    logic          done_reg;
    logic          done_next;
    logic [IW-1:0] cnt_reg;
    logic          acc_reg;
    logic          flag_reg;
    logic          eq_reg;
    logic [IW-1:0] idx_reg;

    logic bit_match;
    logic accept;
    logic consume;
    logic last_bit;
    logic acc_next;

    eq_bit_cell u_cell (
        .a  (bus.a_bit),
        .b  (bus.b_bit),
        .eq (bit_match)
    );

    assign accept   = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && bus.start;
    assign consume  = (state_reg == ST_SHIFT) && bus.bit_valid;
    assign last_bit = (cnt_reg == IW'(W - 1));
    assign acc_next = acc_reg & bit_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_SHIFT;
            ST_SHIFT: if (consume && last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = bus.start ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Status flags are decoded from the next state and registered so that
    // busy/done come straight from flops.
    always_comb begin
        busy_next = (state_next == ST_SHIFT);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            acc_reg  <= 1'b1;
            flag_reg <= 1'b0;
            eq_reg   <= 1'b0;
            idx_reg  <= '0;
        end else if (accept) begin
            cnt_reg  <= '0;
            acc_reg  <= 1'b1;
            flag_reg <= 1'b0;
            eq_reg   <= 1'b0;
            idx_reg  <= '0;
        end else if (consume) begin
            acc_reg <= acc_next;
            cnt_reg <= last_bit ? '0 : cnt_reg + IW'(1);
            // Only the first differing position is latched.
            if (!bit_match && !flag_reg) begin
                idx_reg  <= cnt_reg;
                flag_reg <= 1'b1;
            end
            if (last_bit) begin
                eq_reg <= acc_next;
            end
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.eq           = eq_reg;
    assign bus.mismatch_idx = idx_reg;

endmodule
